// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared mode/state encodings and trace entry layout
package trace_pkg;

    typedef enum logic [1:0] {
        MODE_RING      = 2'd0,
        MODE_FILL_STOP = 2'd1,
        MODE_TRIGGERED = 2'd2,
        MODE_RESERVED  = 2'd3
    } trace_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } trace_state_e;

    localparam int INSTR_W   = 32;
    localparam int WADDR_W   = 5;
    localparam int TS_W      = 32;
    localparam int DROPPED_W = 16;

    // Entry layout from bit 0 upward: wdata | waddr | we | instr | pc | (ts)
    function automatic int off_waddr(input int xlen);
        return xlen;
    endfunction

    function automatic int off_we(input int xlen);
        return xlen + WADDR_W;
    endfunction

    function automatic int off_instr(input int xlen);
        return xlen + WADDR_W + 1;
    endfunction

    function automatic int off_pc(input int xlen);
        return off_instr(xlen) + INSTR_W;
    endfunction

    function automatic int off_ts(input int xlen);
        return off_pc(xlen) + xlen;
    endfunction

    function automatic int entry_w(input int xlen);
`ifdef TRACE_TIMESTAMP_EN
        return off_ts(xlen) + TS_W;
`else
        return off_ts(xlen);
`endif
    endfunction

    localparam int ENTRY_W = entry_w(32);

    // The reserved encoding behaves as RING.
    function automatic logic is_ring(input trace_mode_e m);
        return (m == MODE_RING) || (m == MODE_RESERVED);
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - circular entry storage with optional overwrite-oldest on full
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     overwrite,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             flush;
    logic             do_pop;
    logic             do_write;
    logic             drop_oldest;

    assign flush       = rst | clear;
    assign full        = (count == CW'(DEPTH));
    assign empty       = (count == '0);
    assign do_pop      = pop && !empty;
    // At full the write slot is the head slot, so overwriting means the head moves too.
    assign drop_oldest = push && full && !do_pop && overwrite;
    assign do_write    = push && (!full || do_pop || overwrite);
    assign rdata       = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop || drop_oldest) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_write && !do_pop && !drop_oldest) begin
                count <= count + 1'b1;
            end else if (!do_write && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_write && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/trace_capture_unit.sv
// rtl/trace_capture_unit.sv - retired-instruction trace buffer with register shadow window
// Define TRACE_TIMESTAMP_EN to store a free-running cycle stamp per entry on rd_ts.
module trace_capture_unit
    import trace_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 16,
    parameter int NWATCH     = 5,
    parameter int WATCH_BASE = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       clear,
    input  logic [1:0]                 mode,
    input  logic [XLEN-1:0]            trig_pc,
    input  logic                       commit_valid,
    input  logic [XLEN-1:0]            commit_pc,
    input  logic [INSTR_W-1:0]         commit_instr,
    input  logic                       rf_we,
    input  logic [WADDR_W-1:0]         rf_waddr,
    input  logic [XLEN-1:0]            rf_wdata,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [XLEN-1:0]            rd_pc,
    output logic [INSTR_W-1:0]         rd_instr,
    output logic                       rd_we,
    output logic [WADDR_W-1:0]         rd_waddr,
    output logic [XLEN-1:0]            rd_wdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [DROPPED_W-1:0]       dropped,
    output logic [1:0]                 state,
`ifdef TRACE_TIMESTAMP_EN
    output logic [TS_W-1:0]            rd_ts,
`endif
    output logic [NWATCH*XLEN-1:0]     watch_regs
);

    localparam int CW        = $clog2(DEPTH) + 1;
    localparam int EW        = entry_w(XLEN);
    localparam int OFF_WADDR = off_waddr(XLEN);
    localparam int OFF_WE    = off_we(XLEN);
    localparam int OFF_INSTR = off_instr(XLEN);
    localparam int OFF_PC    = off_pc(XLEN);

    trace_state_e state_q;
    trace_state_e state_d;
    trace_mode_e  mode_q;
    logic         flush;
    logic         ring_q;
    logic         trig_hit;
    logic         push_req;
    logic         do_pop;
    logic         fifo_full;
    logic         fifo_empty;
    logic         fill_hit;
    logic         lost;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] rd_entry;

    assign flush    = rst | clear;
    assign ring_q   = is_ring(mode_q);
    assign trig_hit = (state_q == ST_ARMED) && commit_valid && (commit_pc == trig_pc);
    assign push_req = (commit_valid && (state_q == ST_CAPTURE)) || trig_hit;
    assign rd_valid = !fifo_empty;
    assign do_pop   = rd_valid && rd_ready;
    // Any push at full leaves the count at DEPTH, whether it lands or is discarded.
    assign fill_hit = push_req && (fifo_full || ((count == CW'(DEPTH - 1)) && !do_pop));
    // Commits seen in DONE are records the trace failed to keep.
    assign lost     = (push_req && fifo_full && !do_pop) || (commit_valid && (state_q == ST_DONE));

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
        end
    end

    assign wr_entry = {ts_q, commit_pc, commit_instr, rf_we, rf_waddr, rf_wdata};
    assign rd_ts    = rd_entry[off_ts(XLEN) +: TS_W];
`else
    assign wr_entry = {commit_pc, commit_instr, rf_we, rf_waddr, rf_wdata};
`endif

    trace_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .push      (push_req),
        .pop       (do_pop),
        .overwrite (ring_q),
        .wdata     (wr_entry),
        .rdata     (rd_entry),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rd_wdata = rd_entry[XLEN-1:0];
    assign rd_waddr = rd_entry[OFF_WADDR +: WADDR_W];
    assign rd_we    = rd_entry[OFF_WE];
    assign rd_instr = rd_entry[OFF_INSTR +: INSTR_W];
    assign rd_pc    = rd_entry[OFF_PC +: XLEN];
    assign state    = state_q;

    // Mode is sampled only while idle so a running capture cannot be retargeted.
    always_ff @(posedge clk) begin
        if (flush) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_RING;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE) begin
                mode_q <= trace_mode_e'(mode);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    state_d = (trace_mode_e'(mode) == MODE_TRIGGERED) ? ST_ARMED : ST_CAPTURE;
                ST_ARMED:   state_d = trig_hit ? ST_CAPTURE : ST_ARMED;
                ST_CAPTURE: state_d = (!ring_q && fill_hit) ? ST_DONE : ST_CAPTURE;
                ST_DONE:    state_d = ST_DONE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            overflow <= 1'b0;
            dropped  <= '0;
        end else if (lost) begin
            overflow <= 1'b1;
            if (dropped != '1) begin
                dropped <= dropped + 1'b1;
            end
        end
    end

    // Shadow copies track register writes even while capture is idle or stopped.
    always_ff @(posedge clk) begin
        if (rst) begin
            watch_regs <= '0;
        end else if (commit_valid && rf_we && (rf_waddr != '0)) begin
            for (int i = 0; i < NWATCH; i++) begin
                if (int'(rf_waddr) == WATCH_BASE + i) begin
                    watch_regs[i*XLEN +: XLEN] <= rf_wdata;
                end
            end
        end
    end

endmodule

// File: doc/trace_capture_unit.md
Name: trace_capture_unit

Overview:
- Synthesizable on-chip execution trace buffer for the single-cycle and future multi-cycle datapaths.
- Captures retired-instruction records (PC, instruction, register-file write) into a parametrised circular buffer.
- Keeps shadow copies of a window of architectural registers.
- Offers a valid/ready readout port, so hardware or a bench drains the trace instead of probing hierarchy.

Parameters:
XLEN, 32, datapath/PC/register width
DEPTH, 16, trace entries; power of two, >=2
NWATCH, 5, number of shadowed registers
WATCH_BASE, 8, first shadowed register index (8 = $t0)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
en  in  1  capture enable
clear  in  1  sync flush of buffer, counters, overflow
mode  in  2  0=RING, 1=FILL_STOP, 2=TRIGGERED, 3=reserved (treated as RING)
trig_pc  in  XLEN  trigger PC for TRIGGERED mode
commit_valid  in  1  one instruction retires this cycle
commit_pc  in  XLEN  retiring PC
commit_instr  in  32  retiring instruction word
rf_we  in  1  register write this cycle (qualified by commit_valid)
rf_waddr  in  5  write index
rf_wdata  in  XLEN  write data
rd_valid  out  1  entry available (= !empty)
rd_ready  in  1  consumer pops head when rd_valid
rd_pc  out  XLEN  head entry PC
rd_instr  out  32  head entry instruction
rd_we  out  1  head entry register-write flag
rd_waddr  out  5  head entry write index
rd_wdata  out  XLEN  head entry write data
count  out  $clog2(DEPTH)+1  occupied entries
overflow  out  1  sticky: an entry was lost or overwritten
dropped  out  16  saturating count of lost entries
state  out  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3
watch_regs  out  NWATCH*XLEN  shadow regs, index WATCH_BASE+i at slice i

Behaviour:
- Reset (rst=1 at posedge): pointers=0, count=0, overflow=0, dropped=0, state=IDLE, watch_regs=0.
  - rd_valid=0; rd_* show entry 0 contents, which are don't-care while empty.
- clear: same as reset except watch_regs retained; clear overrides push and pop in the same cycle.
- Push: commit_valid && state==CAPTURE. Entry {pc, instr, rf_we, waddr, wdata} written at wr_ptr; visible on rd_* next cycle if buffer was empty.
- Pop: rd_valid && rd_ready; head advances at the edge.
  - rd_* are combinational from the head slot.
- Pointers wrap modulo DEPTH.
- Simultaneous push+pop at full: normal (count unchanged, no overflow).
- Simultaneous push+pop at empty: the pop is ignored, since rd_valid=0.
- Full push without pop:
  - RING: overwrite oldest and advance rd_ptr; overflow=1, dropped+1.
  - FILL_STOP/TRIGGERED: record discarded; overflow=1, dropped+1.
- dropped saturates at 0xFFFF.
- FSM:
  - IDLE -> CAPTURE on en in modes 0/1/3; IDLE -> ARMED on en in mode 2.
  - ARMED -> CAPTURE on commit_valid && commit_pc==trig_pc. The triggering commit is itself pushed in that cycle.
  - CAPTURE -> DONE when count would reach DEPTH after a push in FILL_STOP/TRIGGERED.
  - RING never enters DONE.
  - DONE holds; pops permitted; no pushes.
  - Any state -> IDLE when en=0. Contents are kept and remain readable.
  - Changing mode is only honoured in IDLE.
- Watch shadow: commit_valid && rf_we && waddr in [WATCH_BASE, WATCH_BASE+NWATCH) updates the slice next edge.
  - This happens regardless of en/state.
  - waddr==0 is never shadowed.
- Reset mid-capture discards all entries; no partial record survives.

Optional Feature:
TRACE_TIMESTAMP_EN:
- Defined: a 32-bit free-running cycle counter (0 at reset, wraps) is stored with each entry and exposed on an extra output rd_ts [31:0].
- Undefined: no counter, no storage, no rd_ts port.

Decomposition:
- Package trace_pkg:
  - mode and state encodings.
  - entry field widths/offsets and ENTRY_W.
  - TS_W=32.
  - DROPPED_W=16.
- Sub-module trace_fifo: parametrised circular storage with wr/rd pointers, count, full/empty, and an overwrite-on-full option input.
- Top-level holds FSM, trigger compare, overflow/dropped, watch shadow.

Test Plan:
- RING, DEPTH=16, 20 commits PC=0x00400000+4k, no pops -> count=16, overflow=1, dropped=4; first pop rd_pc=0x00400010.
- FILL_STOP, 18 commits -> state=DONE after 16th; dropped=2; drain 16 entries in order; rd_valid=0 after, state stays DONE.
- TRIGGERED, trig_pc=0x0040000C, commits from 0x00400000 -> state ARMED until 4th commit; first popped rd_pc=0x0040000C.
- Full buffer with push+pop every cycle for 10 cycles -> count stays 16, overflow=0.
- rf_we waddr=9 wdata=0x0000000A, waddr=0 wdata=0x5 -> watch_regs slice1=0x0000000A, nothing else changes; waddr=13 ignored (NWATCH=5).
- rst asserted mid-CAPTURE with 7 entries -> next cycle count=0, rd_valid=0, state=IDLE, watch_regs=0; clear instead keeps watch_regs.
